// File: rtl/psum_channel_acc_pkg.sv
// Shared constants and lane helpers for the partial-sum adder and channel accumulator.
package psum_channel_acc_pkg;

  localparam int unsigned LANES = 9;
  localparam int unsigned DW    = 32;
  localparam int unsigned DWI   = LANES * DW;
  localparam int unsigned CNT_W = 10;

  // Extract lane idx (DW bits) from a packed LANES*DW bus.
  function automatic logic [DW-1:0] lane_slice(input logic [DWI-1:0] bus,
                                               input int unsigned     idx);
    return DW'(bus >> (idx * DW));
  endfunction

endpackage

// File: rtl/lane_reduce_tree.sv
// Combinational 9-to-1 wrapping adder over the packed partial-sum lanes.
module lane_reduce_tree
  import psum_channel_acc_pkg::*;
(
  input  logic [DWI-1:0] din,
  output logic [DW-1:0]  sum_c
);

  // Two's complement sum modulo 2^DW; synthesis balances the chain into a tree.
  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sum_c = sum_c + lane_slice(din, i);
    end
  end

endmodule

// File: rtl/psum_channel_acc.sv
// Reduces 9 partial-sum lanes per beat, accumulates over cfg_cin beats plus bias,
// applies optional ReLU and emits the result on a valid/ready output.
module psum_channel_acc
  import psum_channel_acc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DWI-1:0]   din,
  input  logic [CNT_W-1:0] cfg_cin,
  input  logic [DW-1:0]    bias,
  input  logic             relu_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    dout,
  output logic             grp_busy
);

  logic [DW-1:0]    lane_sum_c;

  logic             s1_valid;
  logic [DW-1:0]    s1_data;
  logic [DW-1:0]    s1_bias;
  logic [CNT_W-1:0] s1_len;
  logic             s1_relu;

  logic [DW-1:0]    acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] grp_len;
  logic             grp_relu;

  logic             stall;
  logic [DW-1:0]    grp_sum_c;
  logic [CNT_W-1:0] len_c;
  logic             relu_c;
  logic             done_c;

  lane_reduce_tree u_reduce (
    .din   (din),
    .sum_c (lane_sum_c)
  );

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign grp_busy = (cnt != '0) | s1_valid;

  // First beat of a group takes its settings from stage 1; later beats use the latched copy.
  always_comb begin
    grp_sum_c = acc + s1_data;
    len_c     = grp_len;
    relu_c    = grp_relu;
    if (cnt == '0) begin
      grp_sum_c = s1_bias + s1_data;
      len_c     = s1_len;
      relu_c    = s1_relu;
    end
    done_c = s1_valid & (cnt == len_c - CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_bias   <= '0;
      s1_len    <= CNT_W'(1);
      s1_relu   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      grp_len   <= CNT_W'(1);
      grp_relu  <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= lane_sum_c;
        s1_bias <= bias;
        s1_len  <= (cfg_cin == '0) ? CNT_W'(1) : cfg_cin;
        s1_relu <= relu_en;
      end

      // Not stalled: any pending output is being consumed, so only a completion keeps it valid.
      out_valid <= done_c;

      if (s1_valid) begin
        if (cnt == '0) begin
          grp_len  <= len_c;
          grp_relu <= relu_c;
        end
        if (done_c) begin
          dout <= (relu_c & grp_sum_c[DW-1]) ? '0 : grp_sum_c;
          cnt  <= '0;
        end else begin
          acc <= grp_sum_c;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
